simd_shader_core: RTL and testbench

- Parametrised, pipelined successor to the flat per-lane shader datapath.
- A single instruction stream is broadcast to LANES identical lanes. Each lane owns a private NREGS x DATA_W register file.
- Adds over the flat datapath: valid/ready issue handshake, 2-stage pipeline with write-back bypass, per-lane execution mask, HALT/drain state machine.
- Sits between the instruction fetch unit and the lane register/debug interface of the shader top.

---
 rtl/simd_shader_core.sv | 264 ++++++++++++++++++++++++++
 tb/tb_simd_shader_core.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_shader_core.sv
// -----------------------------------------------------------------------------
// simd_shader_core
//
// Purpose:
//   SIMD shader datapath. One instruction stream is broadcast to LANES
//   identical lanes, each with a private NREGS x DATA_W register file.
//   Two pipeline stages (EX, WB) with a WB->EX bypass, a per-lane execution
//   mask, and a RUN -> DRAIN -> HALTED state machine.
//
// Optional feature:
//   SIMD_SHADER_MUL_EN - when defined, opcode 0x0B (MUL) writes the low
//   DATA_W bits of src0*src1. When undefined, 0x0B is an illegal opcode.
//
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   in_valid        instruction valid
//   in_instr[31:0]  opcode[31:26] dst[25:21] src0[20:16] src1[15:11] immd[10:0]
//   in_ready        instruction accepted on in_valid & in_ready
//   retire_valid    one-cycle pulse while an instruction is in write-back
//   retire_opcode   opcode of the retiring instruction
//   illegal         pulses with retire_valid for an undefined opcode
//   halted          core is halted (left only by rst)
//   lane_mask       current execution mask
//   dbg_lane        debug lane select
//   dbg_reg         debug register select
//   dbg_data        combinational read of RF[dbg_lane][dbg_reg]
//
// Handshake: an instruction transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready does not depend on in_valid. in_valid while
// in_ready is low is ignored and the instruction is not consumed.
// -----------------------------------------------------------------------------
module simd_shader_core #(
    parameter int LANES  = 4,
    parameter int NREGS  = 32,
    parameter int DATA_W = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    input  logic [31:0]                                in_instr,
    output logic                                       in_ready,
    output logic                                       retire_valid,
    output logic [5:0]                                 retire_opcode,
    output logic                                       illegal,
    output logic                                       halted,
    output logic [LANES-1:0]                           lane_mask,
    input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] dbg_lane,
    input  logic [4:0]                                 dbg_reg,
    output logic [DATA_W-1:0]                          dbg_data
);

    localparam int RI  = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int SHW = $clog2(DATA_W);

    localparam logic [5:0] OP_NOP     = 6'h00;
    localparam logic [5:0] OP_ADD     = 6'h01;
    localparam logic [5:0] OP_SUB     = 6'h02;
    localparam logic [5:0] OP_AND     = 6'h03;
    localparam logic [5:0] OP_OR      = 6'h04;
    localparam logic [5:0] OP_XOR     = 6'h05;
    localparam logic [5:0] OP_SHL     = 6'h06;
    localparam logic [5:0] OP_SHR     = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_MOVI    = 6'h09;
    localparam logic [5:0] OP_SETMASK = 6'h0A;
`ifdef SIMD_SHADER_MUL_EN
    localparam logic [5:0] OP_MUL     = 6'h0B;
`endif
    localparam logic [5:0] OP_HALT    = 6'h3F;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Register file
    logic [DATA_W-1:0] rf [LANES][NREGS];

    // EX stage registers
    logic        ex_valid;
    logic [5:0]  ex_op;
    logic [4:0]  ex_dst, ex_s0, ex_s1;
    logic [10:0] ex_imm;

    // WB stage registers
    logic              wb_valid;
    logic [5:0]        wb_op;
    logic [4:0]        wb_dst;
    logic              wb_illegal;
    logic [LANES-1:0]  wb_we;
    logic [DATA_W-1:0] wb_res [LANES];

    // EX combinational
    logic              acc;
    logic              ex_writes;
    logic              ex_illegal;
    logic [DATA_W-1:0] ex_imm_sx;
    logic [31:0]       ex_imm_wide;
    logic [LANES-1:0]  setmask_val;
    logic [DATA_W-1:0] op_a    [LANES];
    logic [DATA_W-1:0] op_b    [LANES];
    logic [DATA_W-1:0] alu_res [LANES];

    // Register fields wider than the RF index are tolerated; only the low
    // RI bits select a register.
    logic unused_hi_bits;
    assign unused_hi_bits = ^{ex_dst, ex_s0, ex_s1, wb_dst, dbg_reg};

    assign acc = in_valid & in_ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_RUN: begin
                in_ready = 1'b1;
                if (acc && in_instr[31:26] == OP_HALT) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Nothing is accepted after HALT, so once HALT sits in WB
                // with EX empty the pipeline drains at the next edge.
                if (wb_valid && wb_op == OP_HALT && !ex_valid) state_d = S_HALTED;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: state_d = S_RUN;
        endcase
    end

    // ---------------------------------------------------------------- EX regs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_op    <= '0;
            ex_dst   <= '0;
            ex_s0    <= '0;
            ex_s1    <= '0;
            ex_imm   <= '0;
        end else begin
            ex_valid <= acc;
            if (acc) begin
                ex_op  <= in_instr[31:26];
                ex_dst <= in_instr[25:21];
                ex_s0  <= in_instr[20:16];
                ex_s1  <= in_instr[15:11];
                ex_imm <= in_instr[10:0];
            end
        end
    end

    // ---------------------------------------------------------------- decode
    always_comb begin
        ex_writes  = 1'b0;
        ex_illegal = 1'b0;
        case (ex_op)
            OP_NOP, OP_SETMASK, OP_HALT: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_ADDI, OP_MOVI: ex_writes = 1'b1;
`ifdef SIMD_SHADER_MUL_EN
            OP_MUL: ex_writes = 1'b1;
`endif
            default: ex_illegal = 1'b1;
        endcase
    end

    assign ex_imm_sx   = {{(DATA_W-11){ex_imm[10]}}, ex_imm};
    assign ex_imm_wide = {21'b0, ex_imm};
    // Lanes above immd bit 10 receive 0 through the zero-extended word.
    assign setmask_val = ex_imm_wide[LANES-1:0];

    // ---------------------------------------------------------------- operands + ALU
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            op_a[l] = rf[l][ex_s0[RI-1:0]];
            op_b[l] = rf[l][ex_s1[RI-1:0]];
            // Bypass honours the WB lane's write enable, so a masked-off
            // lane keeps reading the stale (unwritten) RF value.
            if (wb_we[l] && wb_dst[RI-1:0] == ex_s0[RI-1:0]) op_a[l] = wb_res[l];
            if (wb_we[l] && wb_dst[RI-1:0] == ex_s1[RI-1:0]) op_b[l] = wb_res[l];

            alu_res[l] = '0;
            case (ex_op)
                OP_ADD:  alu_res[l] = op_a[l] + op_b[l];
                OP_SUB:  alu_res[l] = op_a[l] - op_b[l];
                OP_AND:  alu_res[l] = op_a[l] & op_b[l];
                OP_OR:   alu_res[l] = op_a[l] | op_b[l];
                OP_XOR:  alu_res[l] = op_a[l] ^ op_b[l];
                OP_SHL:  alu_res[l] = op_a[l] << op_b[l][SHW-1:0];
                OP_SHR:  alu_res[l] = op_a[l] >> op_b[l][SHW-1:0];
                OP_ADDI: alu_res[l] = op_a[l] + ex_imm_sx;
                OP_MOVI: alu_res[l] = ex_imm_sx;
`ifdef SIMD_SHADER_MUL_EN
                OP_MUL:  alu_res[l] = op_a[l] * op_b[l];
`endif
                default: alu_res[l] = '0;
            endcase
        end
    end

    // ---------------------------------------------------------------- WB regs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_op      <= '0;
            wb_dst     <= '0;
            wb_illegal <= 1'b0;
            wb_we      <= '0;
            for (int l = 0; l < LANES; l++) wb_res[l] <= '0;
        end else begin
            wb_valid <= ex_valid;
            if (ex_valid) begin
                wb_op      <= ex_op;
                wb_dst     <= ex_dst;
                wb_illegal <= ex_illegal;
                for (int l = 0; l < LANES; l++) wb_res[l] <= alu_res[l];
            end
            for (int l = 0; l < LANES; l++)
                wb_we[l] <= ex_valid & ex_writes & lane_mask[l];
        end
    end

    // ---------------------------------------------------------------- lane mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_mask <= '1;
        end else if (ex_valid && ex_op == OP_SETMASK) begin
            lane_mask <= setmask_val;
        end
    end

    // ---------------------------------------------------------------- register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < LANES; l++)
                for (int r = 0; r < NREGS; r++)
                    rf[l][r] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++)
                if (wb_we[l]) rf[l][wb_dst[RI-1:0]] <= wb_res[l];
        end
    end

    // ---------------------------------------------------------------- outputs
    assign retire_valid  = wb_valid;
    assign retire_opcode = wb_op;
    assign illegal       = wb_valid & wb_illegal;

    always_comb begin
        dbg_data = '0;
        if (int'(dbg_lane) < LANES) dbg_data = rf[dbg_lane][dbg_reg[RI-1:0]];
    end

endmodule

// File: tb/tb_simd_shader_core.sv
module tb_simd_shader_core;

  localparam int LANES  = 4;
  localparam int NREGS  = 32;
  localparam int DATA_W = 32;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int W      = 39;  // {retire cycle[31:0], illegal, opcode[5:0]}

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [31:0]       in_instr;
  logic              in_ready;
  logic              retire_valid;
  logic [5:0]        retire_opcode;
  logic              illegal;
  logic              halted;
  logic [LANES-1:0]  lane_mask;
  logic [LW-1:0]     dbg_lane;
  logic [4:0]        dbg_reg;
  logic [DATA_W-1:0] dbg_data;

  simd_shader_core #(.LANES(LANES), .NREGS(NREGS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .retire_valid(retire_valid),
    .retire_opcode(retire_opcode), .illegal(illegal), .halted(halted),
    .lane_mask(lane_mask), .dbg_lane(dbg_lane), .dbg_reg(dbg_reg),
    .dbg_data(dbg_data)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------------------------------------------------------- reference model
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] ref_rf [LANES][NREGS];
  logic [LANES-1:0]  ref_mask;
  bit                ref_running;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_illegal(input logic [5:0] op);
    bit legal;
    legal = (op <= 6'h0A) || (op == 6'h3F);
`ifdef SIMD_SHADER_MUL_EN
    if (op == 6'h0B) legal = 1'b1;
`endif
    return !legal;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input int d, input int s0,
                                     input int s1, input logic [10:0] imm);
    return {op, 5'(d), 5'(s0), 5'(s1), imm};
  endfunction

  // Executes one instruction in program order on the architectural state.
  function automatic void model_exec(input logic [31:0] ins);
    logic [5:0]        op;
    logic [4:0]        d, s0, s1;
    logic [DATA_W-1:0] imm, a, b, r;
    bit                wr;
    op  = ins[31:26];
    d   = ins[25:21];
    s0  = ins[20:16];
    s1  = ins[15:11];
    imm = DATA_W'($signed(ins[10:0]));
    for (int l = 0; l < LANES; l++) begin
      a  = ref_rf[l][s0];
      b  = ref_rf[l][s1];
      wr = 1'b1;
      r  = '0;
      case (op)
        6'h01: r = a + b;
        6'h02: r = a - b;
        6'h03: r = a & b;
        6'h04: r = a | b;
        6'h05: r = a ^ b;
        6'h06: r = a << (b % DATA_W);
        6'h07: r = a >> (b % DATA_W);
        6'h08: r = a + imm;
        6'h09: r = imm;
`ifdef SIMD_SHADER_MUL_EN
        6'h0B: r = a * b;
`endif
        default: wr = 1'b0;
      endcase
      if (wr && ref_mask[l]) ref_rf[l][d] = r;
    end
    if (op == 6'h0A) ref_mask = ins[LANES-1:0];
    if (op == 6'h3F) ref_running = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < NREGS; r++)
        ref_rf[l][r] = '0;
    ref_mask    = '1;
    ref_running = 1'b1;
    exp_q.delete();
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic issue(input logic [31:0] ins);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    chk("in_ready", in_ready, ref_running);
    if (ref_running) begin
      exp_q.push_back({32'(cycle + 2), model_illegal(ins[31:26]), ins[31:26]});
      model_exec(ins);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reg(input int l, input int r, input logic [DATA_W-1:0] exp);
    @(negedge clk);
    dbg_lane = LW'(l);
    dbg_reg  = 5'(r);
    #1;
    chk($sformatf("reg_l%0d_r%0d", l, r), dbg_data, exp);
  endtask

  task automatic scan_rf(input string tag);
    @(negedge clk);
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < NREGS; r++) begin
        dbg_lane = LW'(l);
        dbg_reg  = 5'(r);
        #1;
        chk($sformatf("%s_rf_l%0d_r%0d", tag, l, r), dbg_data, ref_rf[l][r]);
      end
    chk({tag, "_lane_mask"}, lane_mask, ref_mask);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      if (retire_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL retire_unexpected: opcode %0h with no expected retire", retire_opcode);
        end else begin
          e = exp_q.pop_front();
          chk("retire_cycle", 64'(cycle), 64'(e[38:7]));
          chk("retire_opcode", retire_opcode, e[5:0]);
          chk("retire_illegal", illegal, e[6]);
        end
      end else if (illegal) begin
        chk("illegal_without_retire", illegal, 1'b0);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  logic [5:0] rand_ops [14] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                                6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h15, 6'h20};

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    dbg_lane = '0;
    dbg_reg  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_retire_valid", retire_valid, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_lane_mask", lane_mask, 4'hF);
    scan_rf("reset");

    // Back-to-back dependent ADD
    issue(mk(6'h09, 1, 0, 0, 11'd5));
    issue(mk(6'h09, 2, 0, 0, 11'd7));
    issue(mk(6'h01, 3, 1, 2, 11'd0));
    idle(3);
    for (int l = 0; l < LANES; l++) check_reg(l, 3, 32'd12);

    // Sign-extended immediate and wrap via bypass
    issue(mk(6'h09, 1, 0, 0, 11'h7FF));
    issue(mk(6'h08, 2, 1, 0, 11'd2));
    idle(3);
    for (int l = 0; l < LANES; l++) begin
      check_reg(l, 1, 32'hFFFF_FFFF);
      check_reg(l, 2, 32'd1);
    end

    // Masked write
    issue(mk(6'h0A, 0, 0, 0, 11'b0101));
    issue(mk(6'h09, 4, 0, 0, 11'd9));
    idle(3);
    check_reg(0, 4, 32'd9);
    check_reg(1, 4, 32'd0);
    check_reg(2, 4, 32'd9);
    check_reg(3, 4, 32'd0);
    chk("setmask_lane_mask", lane_mask, 4'b0101);
    issue(mk(6'h0A, 0, 0, 0, 11'hF));

    // Shifts at the boundary
    issue(mk(6'h09, 1, 0, 0, 11'd1));
    issue(mk(6'h09, 2, 0, 0, 11'd31));
    issue(mk(6'h06, 3, 1, 2, 11'd0));
    issue(mk(6'h07, 4, 3, 2, 11'd0));
    idle(3);
    check_reg(0, 3, 32'h8000_0000);
    check_reg(2, 4, 32'd1);

    // Illegal opcode and the optional multiply
    issue(mk(6'h15, 5, 1, 2, 11'd0));
    issue(mk(6'h09, 1, 0, 0, 11'h400));
    issue(mk(6'h0B, 2, 1, 1, 11'd0));
    idle(3);
`ifdef SIMD_SHADER_MUL_EN
    check_reg(1, 2, 32'h0010_0000);
`else
    check_reg(1, 2, 32'd31);
`endif
    check_reg(3, 5, 32'd0);
    scan_rf("directed");

    // Randomized stream with small register window for dense hazards
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      op = rand_ops[$urandom_range(0, 13)];
      issue(mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               11'($urandom_range(0, 2047))));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    scan_rf("random");

    // HALT with continuous follow-on traffic
    issue(mk(6'h0A, 0, 0, 0, 11'hF));
    issue(mk(6'h09, 5, 0, 0, 11'd77));
    issue(mk(6'h3F, 0, 0, 0, 11'd0));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = mk(6'h01, 5, 5, 5, 11'd0);
      chk("halt_in_ready", in_ready, 1'b0);
      chk("halt_halted", halted, (k >= 2));
    end
    @(negedge clk);
    in_valid = 1'b0;
    idle(2);
    chk("halt_sticky", halted, 1'b1);
    for (int l = 0; l < LANES; l++) check_reg(l, 5, 32'd77);
    scan_rf("halted");

    // Reset exits HALTED; then reset mid-stream discards in-flight work
    apply_reset();
    @(negedge clk);
    chk("rst2_halted", halted, 1'b0);
    chk("rst2_in_ready", in_ready, 1'b1);
    issue(mk(6'h09, 6, 0, 0, 11'd3));
    issue(mk(6'h09, 7, 0, 0, 11'd4));
    idle(3);
    check_reg(0, 6, 32'd3);
    issue(mk(6'h09, 8, 0, 0, 11'd5));
    issue(mk(6'h09, 9, 0, 0, 11'd6));
    apply_reset();
    idle(3);
    chk("rst3_halted", halted, 1'b0);
    chk("rst3_in_ready", in_ready, 1'b1);
    chk("rst3_retire_valid", retire_valid, 1'b0);
    scan_rf("midreset");

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
